// File: rtl/dvbc_derandomizer_pkg.sv
// Shared constants, types and helpers for the DVB-C energy-dispersal
// derandomizer (and its transmit-side randomizer counterpart).
//   TS framing : 188-byte MPEG-TS packets, 8-packet dispersal groups
//   Sync bytes : 0x47 normally, 0xB8 (inverted) on the first packet of a group
//   PRBS       : x^15 + x^14 + 1, register r[1:15] held as state[14:0],
//                state[14] = r1 ... state[0] = r15
package dvbc_derandomizer_pkg;

  localparam int unsigned TS_PKT_LEN = 188;
  localparam int unsigned GRP_PKTS   = 8;

  localparam logic [7:0]  TS_SYNC     = 8'h47;
  localparam logic [7:0]  TS_SYNC_INV = 8'hB8;
  localparam logic [14:0] PRBS_INIT   = 15'b100101010000000;

  localparam int unsigned BYTE_CNT_W = $clog2(TS_PKT_LEN);
  localparam int unsigned PKT_IDX_W  = $clog2(GRP_PKTS);

  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(TS_PKT_LEN - 1);
  localparam logic [PKT_IDX_W-1:0]  LAST_PKT  = PKT_IDX_W'(GRP_PKTS - 1);

  typedef logic [14:0] prbs_state_t;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_VERIFY,
    ST_LOCK
  } state_e;

  // Sync byte expected at the start of packet pkt_idx within a group.
  function automatic logic [7:0] expected_sync(input logic [PKT_IDX_W-1:0] pkt_idx);
    return (pkt_idx == '0) ? TS_SYNC_INV : TS_SYNC;
  endfunction

endpackage

// File: rtl/dvbc_derandomizer_if.sv
// Byte-stream interface of the derandomizer.
//   data_i/valid_i        : received byte stream from the RS decoder
//   data_o/valid_o/sop_o  : descrambled TS stream, sop_o flags sync bytes
//   lock_o                : framing is locked
// slave  = derandomizer side, master = upstream/downstream side.
interface dvbc_derandomizer_if;

  logic [7:0] data_i;
  logic       valid_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       sop_o;
  logic       lock_o;

  modport slave (
    input  data_i, valid_i,
    output data_o, valid_o, sop_o, lock_o
  );

  modport master (
    output data_i, valid_i,
    input  data_o, valid_o, sop_o, lock_o
  );

endinterface

// File: rtl/dvbc_prbs_byte.sv
// Combinational one-byte step of the DVB-C dispersal PRBS (x^15 + x^14 + 1).
// Shared by the receive derandomizer and the transmit randomizer.
//   state_i : current PRBS register
//   prbs_o  : 8 PRBS output bits, first generated bit in bit 7
//   state_o : register after 8 steps
module dvbc_prbs_byte
  import dvbc_derandomizer_pkg::*;
(
  input  prbs_state_t state_i,
  output logic [7:0]  prbs_o,
  output prbs_state_t state_o
);

  always_comb begin
    prbs_state_t st;
    logic        fb;
    // NOTE: every variable written here gets a value before any branch or
    // loop can skip it; a path that leaves one unassigned infers a latch.
    st     = state_i;
    fb     = 1'b0;
    prbs_o = '0;
    for (int i = 7; i >= 0; i--) begin
      fb        = st[1] ^ st[0];     // r14 ^ r15
      st        = {fb, st[14:1]};    // r[2:15] <= r[1:14], r1 <= out
      prbs_o[i] = fb;
    end
    state_o = st;
  end

endmodule

// File: rtl/dvbc_derandomizer.sv
// DVB-C energy-dispersal derandomizer (receive side, after the RS decoder).
// Finds packet/group alignment from the inverted 0xB8 sync, descrambles the
// payload with the x^15+x^14+1 PRBS and restores every sync byte to 0x47.
//   clk_i   : clock
//   rst_i   : asynchronous, active-high reset
//   bus     : dvbc_derandomizer_if.slave
//             data_i/valid_i in; data_o/valid_o/sop_o/lock_o out, all registered
// Parameters:
//   LOCK_CNT   : consecutive correct group syncs (incl. the first) to lock
//   UNLOCK_CNT : consecutive wrong sync positions while locked to drop lock
module dvbc_derandomizer
  import dvbc_derandomizer_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 2,
  parameter int unsigned UNLOCK_CNT = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  dvbc_derandomizer_if.slave   bus
);

  localparam int unsigned     CNT_W      = 4;
  localparam logic [CNT_W-1:0] LOCK_TGT   = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] UNLOCK_TGT = CNT_W'(UNLOCK_CNT);

  state_e                  state_q,    state_d;
  logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [PKT_IDX_W-1:0]    pkt_idx_q,  pkt_idx_d;
  logic [CNT_W-1:0]        hit_q,      hit_d;
  logic [CNT_W-1:0]        miss_q,     miss_d;
  prbs_state_t             prbs_q,     prbs_d;
  logic [7:0]              data_q,     data_d;
  logic                    valid_q,    valid_d;
  logic                    sop_q,      sop_d;
  logic                    lock_q,     lock_d;

  logic [7:0]  prbs_byte;
  prbs_state_t prbs_adv;

  dvbc_prbs_byte u_prbs (
    .state_i (prbs_q),
    .prbs_o  (prbs_byte),
    .state_o (prbs_adv)
  );

  logic at_sync;
  logic sync_ok;
  logic drop;

  assign at_sync = (byte_cnt_q == '0);
  assign sync_ok = (bus.data_i == expected_sync(pkt_idx_q));

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    pkt_idx_d  = pkt_idx_q;
    hit_d      = hit_q;
    miss_d     = miss_q;
    prbs_d     = prbs_q;
    data_d     = data_q;   // data_o holds its last value when nothing is output
    valid_d    = 1'b0;
    sop_d      = 1'b0;
    drop       = 1'b0;

    if (bus.valid_i) begin
      // Free-running framing used while VERIFY/LOCK; HUNT overrides it below.
      if (byte_cnt_q == LAST_BYTE) begin
        byte_cnt_d = '0;
        pkt_idx_d  = (pkt_idx_q == LAST_PKT) ? '0 : pkt_idx_q + PKT_IDX_W'(1);
      end else begin
        byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
      end
      // The group start reloads the PRBS; the other seven sync bytes still
      // consume one PRBS byte even though they are not scrambled.
      prbs_d = (at_sync && pkt_idx_q == '0) ? PRBS_INIT : prbs_adv;

      case (state_q)
        ST_HUNT: begin
          byte_cnt_d = '0;
          pkt_idx_d  = '0;
          prbs_d     = prbs_q;
          if (bus.data_i == TS_SYNC_INV) begin
            byte_cnt_d = BYTE_CNT_W'(1);
            prbs_d     = PRBS_INIT;
            hit_d      = CNT_W'(1);
            miss_d     = '0;
            if (LOCK_TGT == CNT_W'(1)) begin
              state_d = ST_LOCK;
              valid_d = 1'b1;
              sop_d   = 1'b1;
              data_d  = TS_SYNC;
            end else begin
              state_d = ST_VERIFY;
            end
          end
        end

        ST_VERIFY: begin
          if (at_sync) begin
            if (!sync_ok) begin
              drop = 1'b1;
            end else if (pkt_idx_q == '0) begin
              hit_d = hit_q + CNT_W'(1);
              if (hit_q + CNT_W'(1) == LOCK_TGT) begin
                // Lock takes effect on this very sync byte, so it is output.
                state_d = ST_LOCK;
                miss_d  = '0;
                valid_d = 1'b1;
                sop_d   = 1'b1;
                data_d  = TS_SYNC;
              end
            end
          end
        end

        ST_LOCK: begin
          valid_d = 1'b1;
          if (at_sync) begin
            sop_d  = 1'b1;
            data_d = TS_SYNC;
            if (sync_ok) begin
              miss_d = '0;
            end else if (miss_q + CNT_W'(1) == UNLOCK_TGT) begin
              drop = 1'b1;
            end else begin
              miss_d = miss_q + CNT_W'(1);
            end
          end else begin
            data_d = bus.data_i ^ prbs_byte;
          end
        end

        default: drop = 1'b1;
      endcase

      // Back to HUNT: the triggering byte is discarded, never reused as a start.
      if (drop) begin
        state_d    = ST_HUNT;
        byte_cnt_d = '0;
        pkt_idx_d  = '0;
        hit_d      = '0;
        miss_d     = '0;
        prbs_d     = PRBS_INIT;
        valid_d    = 1'b0;
        sop_d      = 1'b0;
        data_d     = data_q;
      end
    end

    lock_d = (state_d == ST_LOCK);
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge values no matter how the statements are ordered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_HUNT;
      byte_cnt_q <= '0;
      pkt_idx_q  <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
      prbs_q     <= PRBS_INIT;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      pkt_idx_q  <= pkt_idx_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      prbs_q     <= prbs_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      lock_q     <= lock_d;
    end
  end

  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.sop_o   = sop_q;
  assign bus.lock_o  = lock_q;

endmodule

// File: tb/tb_dvbc_derandomizer.sv
// Self-checking bench for dvbc_derandomizer.
// A bit-serial randomizer model builds scrambled streams plus the original TS;
// the DUT output for every input byte is recorded and compared against the
// expected lock window and the original bytes.
module tb_dvbc_derandomizer;

  localparam int PKT_LEN   = 188;
  localparam int GRP_LEN   = 8 * PKT_LEN;
  localparam int MAX_BYTES = 16 * GRP_LEN;

  logic clk_i = 1'b0;
  logic rst_i;

  dvbc_derandomizer_if bus ();

  dvbc_derandomizer #(
    .LOCK_CNT   (2),
    .UNLOCK_CNT (3)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks;
  int n_errors;

  logic [7:0] orig_mem [MAX_BYTES];
  logic [7:0] in_mem   [MAX_BYTES];
  logic       exp_v    [MAX_BYTES];
  logic [7:0] out_data [MAX_BYTES];
  logic       out_v    [MAX_BYTES];
  logic       out_sop  [MAX_BYTES];
  logic       out_lock [MAX_BYTES];
  int         n_bytes;
  int         first_valid;
  int         gap_bad;

  bit model_r [1:15];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_load();
    model_r = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  endtask

  task automatic model_byte(output logic [7:0] pb);
    bit fb;
    pb = '0;
    for (int s = 0; s < 8; s++) begin
      fb = model_r[14] ^ model_r[15];
      for (int k = 15; k >= 2; k--) model_r[k] = model_r[k-1];
      model_r[1] = fb;
      pb = {pb[6:0], fb};
    end
  endtask

  // Scrambled payload bytes are kept away from 0xB8 so that a DUT hunting
  // mid-stream only ever starts on a genuine group sync.
  task automatic build_golden(input int n_groups, input int seed);
    logic [7:0] pb;
    logic [7:0] o;
    int idx;
    n_bytes = n_groups * GRP_LEN;
    for (int g = 0; g < n_groups; g++)
      for (int p = 0; p < 8; p++)
        for (int b = 0; b < PKT_LEN; b++) begin
          idx = g * GRP_LEN + p * PKT_LEN + b;
          if (b == 0) begin
            orig_mem[idx] = 8'h47;
            if (p == 0) begin
              model_load();
              in_mem[idx] = 8'hB8;
            end else begin
              model_byte(pb);
              in_mem[idx] = 8'h47;
            end
          end else begin
            model_byte(pb);
            o = 8'(g * 29 + p * 53 + b * 7 + seed);
            if ((o ^ pb) == 8'hB8) o = o ^ 8'h01;
            orig_mem[idx] = o;
            in_mem[idx]   = o ^ pb;
          end
        end
  endtask

  task automatic build_garbage(input int n);
    logic [7:0] g;
    n_bytes = n;
    for (int i = 0; i < n; i++) begin
      g = 8'(i * 37 + 11);
      if (g == 8'hB8 || g == 8'h47) g = 8'h5A;
      in_mem[i]   = g;
      orig_mem[i] = g;
    end
    in_mem[5]   = 8'hB8;
    in_mem[400] = 8'hB8;
    in_mem[900] = 8'hB8;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < MAX_BYTES; i++) exp_v[i] = 1'b0;
  endtask

  task automatic set_exp(input int from, input int to);
    for (int i = from; i < to; i++) exp_v[i] = 1'b1;
  endtask

  task automatic apply_reset();
    rst_i       = 1'b1;
    bus.valid_i = 1'b0;
    bus.data_i  = 8'h00;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  // Drives in_mem[0..n_bytes-1]; gap_pct percent of cycles are valid_i=0 with
  // 0xB8 on the bus. A reset pulse is inserted before byte reset_at (-1: none).
  task automatic run_stream(input int gap_pct, input int reset_at);
    int idx;
    logic [7:0] held;
    idx         = 0;
    first_valid = -1;
    gap_bad     = 0;
    while (idx < n_bytes) begin
      if (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) begin
        bus.valid_i = 1'b0;
        bus.data_i  = 8'hB8;
        held        = bus.data_o;
        @(posedge clk_i);
        #1;
        if (bus.valid_o !== 1'b0 || bus.sop_o !== 1'b0 || bus.data_o !== held) gap_bad++;
      end else begin
        if (idx == reset_at) begin
          #3;
          rst_i = 1'b1;
          #1;
          check("rst_mid_valid", bus.valid_o, 0);
          check("rst_mid_sop",   bus.sop_o,   0);
          check("rst_mid_lock",  bus.lock_o,  0);
          check("rst_mid_data",  bus.data_o,  0);
          #2;
          rst_i = 1'b0;
        end
        bus.valid_i = 1'b1;
        bus.data_i  = in_mem[idx];
        @(posedge clk_i);
        #1;
        out_v[idx]    = bus.valid_o;
        out_data[idx] = bus.data_o;
        out_sop[idx]  = bus.sop_o;
        out_lock[idx] = bus.lock_o;
        if (bus.valid_o === 1'b1 && first_valid < 0) first_valid = idx;
        idx++;
      end
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic eval_stream(input string tag);
    int bad_v, bad_l, bad_s, bad_d;
    logic sop_exp;
    bad_v = 0; bad_l = 0; bad_s = 0; bad_d = 0;
    for (int i = 0; i < n_bytes; i++) begin
      if (out_v[i] !== exp_v[i]) bad_v++;
      if (out_lock[i] !== exp_v[i]) bad_l++;
      sop_exp = exp_v[i] && (i % PKT_LEN == 0);
      if (out_sop[i] !== sop_exp) bad_s++;
      if (exp_v[i] && out_data[i] !== orig_mem[i]) bad_d++;
    end
    check({tag, "_valid_bad"}, bad_v, 0);
    check({tag, "_lock_bad"},  bad_l, 0);
    check({tag, "_sop_bad"},   bad_s, 0);
    check({tag, "_data_bad"},  bad_d, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached before the end of the run");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_i       = 1'b1;
    bus.valid_i = 1'b0;
    bus.data_i  = 8'h00;

    // Reset state
    apply_reset();
    check("reset_valid", bus.valid_o, 0);
    check("reset_sop",   bus.sop_o,   0);
    check("reset_lock",  bus.lock_o,  0);
    check("reset_data",  bus.data_o,  0);

    // 1: golden 16-group stream, lock on the second group's 0xB8
    build_golden(16, 3);
    clear_exp();
    set_exp(GRP_LEN, n_bytes);
    run_stream(0, -1);
    eval_stream("s1");
    check("s1_first_valid_idx", first_valid, GRP_LEN);

    // 2: hand-computed PRBS bytes 0x03, 0xF6 on zero payload after lock
    apply_reset();
    build_golden(2, 7);
    in_mem[GRP_LEN + 1] = 8'h00;
    in_mem[GRP_LEN + 2] = 8'h00;
    run_stream(0, -1);
    check("s2_no_out_in_verify", out_v[GRP_LEN - 1],    0);
    check("s2_sync_valid",       out_v[GRP_LEN],        1);
    check("s2_sync_lock",        out_lock[GRP_LEN],     1);
    check("s2_sync_sop",         out_sop[GRP_LEN],      1);
    check("s2_sync_data",        out_data[GRP_LEN],     8'h47);
    check("s2_byte1_data",       out_data[GRP_LEN + 1], 8'h03);
    check("s2_byte1_sop",        out_sop[GRP_LEN + 1],  0);
    check("s2_byte2_data",       out_data[GRP_LEN + 2], 8'hF6);

    // 3: garbage with stray 0xB8 never locks, then a clean stream locks normally
    apply_reset();
    build_garbage(1300);
    clear_exp();
    run_stream(0, -1);
    eval_stream("s3_garbage");
    build_golden(3, 17);
    clear_exp();
    set_exp(GRP_LEN, n_bytes);
    run_stream(0, -1);
    eval_stream("s3_recover");
    check("s3_first_valid_idx", first_valid, GRP_LEN);

    // 4: two bad syncs across a group boundary keep lock, three drop it
    apply_reset();
    build_golden(6, 11);
    in_mem[2 * GRP_LEN + 7 * PKT_LEN] = 8'h00;
    in_mem[3 * GRP_LEN]               = 8'h47;
    in_mem[3 * GRP_LEN + 3 * PKT_LEN] = 8'h00;
    in_mem[3 * GRP_LEN + 4 * PKT_LEN] = 8'h00;
    in_mem[3 * GRP_LEN + 5 * PKT_LEN] = 8'h00;
    clear_exp();
    set_exp(GRP_LEN, 3 * GRP_LEN + 5 * PKT_LEN);
    set_exp(5 * GRP_LEN, 6 * GRP_LEN);
    run_stream(0, -1);
    eval_stream("s4");
    check("s4_lock_bad_group_sync", out_lock[3 * GRP_LEN], 1);
    check("s4_lock_after_2nd_miss", out_lock[3 * GRP_LEN + 4 * PKT_LEN], 1);
    check("s4_lock_after_3rd_miss", out_lock[3 * GRP_LEN + 5 * PKT_LEN], 0);

    // 5: 30% valid_i gaps give the same output bytes
    apply_reset();
    build_golden(6, 3);
    clear_exp();
    set_exp(GRP_LEN, n_bytes);
    run_stream(30, -1);
    eval_stream("s5");
    check("s5_gap_bad", gap_bad, 0);

    // 6: reset pulse mid-packet while locked
    apply_reset();
    build_golden(4, 23);
    clear_exp();
    set_exp(GRP_LEN, GRP_LEN + 2 * PKT_LEN + 50);
    set_exp(3 * GRP_LEN, 4 * GRP_LEN);
    run_stream(0, GRP_LEN + 2 * PKT_LEN + 50);
    eval_stream("s6");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
